// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ
// requesters and registers the result into a valid/ready response slot that
// is tagged with the owning requester's index.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   per-requester handshake (at most one ready bit high)
//   req_a_i/b_i           packed operands, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ctl_i/shamt_i     packed ALU op (4b) and shift amount (5b) per requester
//   alu_*_o, alu_result_i drive to / result from the external combinational ALU
//   rsp_valid_o/ready_i   response handshake
//   rsp_id_o              index of the requester owning the response
//   rsp_result_o/zero_o   captured result and its all-bits-zero flag
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter logic [3:0]  ALU_ADD    = 4'h0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*4-1:0]          req_ctl_i,
  input  logic [NUM_REQ*5-1:0]          req_shamt_i,
  output logic [DATA_WIDTH-1:0]         alu_a_o,
  output logic [DATA_WIDTH-1:0]         alu_b_o,
  output logic [3:0]                    alu_ctl_o,
  output logic [4:0]                    alu_shamt_o,
  input  logic [DATA_WIDTH-1:0]         alu_result_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_result_o,
  output logic                          rsp_zero_o
);

  localparam int unsigned CTL_W   = 4;
  localparam int unsigned SHAMT_W = 5;
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_found;
  logic            adv;
  logic            fire;

  // First valid requester after the last-granted one, wrapping modulo NUM_REQ.
  always_comb begin : grant_search
    logic [ID_W-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // The response slot can take a new result when empty or draining this cycle.
  assign adv  = !rsp_valid_o || rsp_ready_i;
  assign fire = gnt_found && adv && !rst_i;

  always_comb begin : ready_decode
    req_ready_o = '0;
    if (fire) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  // ALU follows the grant even when stalled, so the result is ready on resume.
  always_comb begin : alu_drive
    alu_a_o     = '0;
    alu_b_o     = '0;
    alu_ctl_o   = ALU_ADD;
    alu_shamt_o = '0;
    if (gnt_found) begin
      alu_a_o     = req_a_i[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      alu_b_o     = req_b_i[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      alu_ctl_o   = req_ctl_i[32'(gnt_idx)*CTL_W +: CTL_W];
      alu_shamt_o = req_shamt_i[32'(gnt_idx)*SHAMT_W +: SHAMT_W];
    end
  end

  // Response register and round-robin pointer; pointer moves only on accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= '0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
      ptr          <= PTR_RST;
    end else if (fire) begin
      rsp_valid_o  <= 1'b1;
      rsp_id_o     <= gnt_idx;
      rsp_result_o <= alu_result_i;
      rsp_zero_o   <= (alu_result_i == '0);
      ptr          <= gnt_idx;
    end else if (rsp_valid_o && rsp_ready_i) begin
      rsp_valid_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU and a response
// scoreboard: stimulus pushes expected responses, a monitor pops on handshake.
module tb_alu_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 2;
  localparam int unsigned IDW = 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  res;
    logic           zero;
  } rsp_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            rst_i;
  logic [NR-1:0]   req_valid;
  logic [DW-1:0]   a   [NR];
  logic [DW-1:0]   b   [NR];
  logic [3:0]      ctl [NR];
  logic [4:0]      sh  [NR];
  logic            rsp_ready;

  logic [NR*DW-1:0] req_a_i, req_b_i;
  logic [NR*4-1:0]  req_ctl_i;
  logic [NR*5-1:0]  req_shamt_i;
  logic [NR-1:0]    req_ready_o;
  logic [DW-1:0]    alu_a_o, alu_b_o, alu_result;
  logic [3:0]       alu_ctl_o;
  logic [4:0]       alu_shamt_o;
  logic             rsp_valid_o, rsp_zero_o;
  logic [IDW-1:0]   rsp_id_o;
  logic [DW-1:0]    rsp_result_o;

  assign req_a_i     = {a[1], a[0]};
  assign req_b_i     = {b[1], b[0]};
  assign req_ctl_i   = {ctl[1], ctl[0]};
  assign req_shamt_i = {sh[1], sh[0]};

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    alu_result = '0;
    case (alu_ctl_o)
      OP_ADD:  alu_result = alu_a_o + alu_b_o;
      OP_SUB:  alu_result = alu_a_o - alu_b_o;
      OP_AND:  alu_result = alu_a_o & alu_b_o;
      OP_OR:   alu_result = alu_a_o | alu_b_o;
      OP_XOR:  alu_result = alu_a_o ^ alu_b_o;
      OP_SLL:  alu_result = alu_a_o << alu_shamt_o;
      OP_SRL:  alu_result = alu_a_o >> alu_shamt_o;
      OP_SRA:  alu_result = DW'($signed(alu_a_o) >>> alu_shamt_o);
      default: alu_result = '0;
    endcase
  end

  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_ctl_i    (req_ctl_i),
    .req_shamt_i  (req_shamt_i),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_ctl_o    (alu_ctl_o),
    .alu_shamt_o  (alu_shamt_o),
    .alu_result_i (alu_result),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id_o),
    .rsp_result_o (rsp_result_o),
    .rsp_zero_o   (rsp_zero_o)
  );

  int   n_tests  = 0;
  int   n_failed = 0;
  int   n_popped = 0;
  rsp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t mk(input logic [IDW-1:0] id, input logic [DW-1:0] res, input logic z);
    rsp_t r;
    r.id   = id;
    r.res  = res;
    r.zero = z;
    return r;
  endfunction

  task automatic drive(input int k, input logic v, input logic [DW-1:0] aa, input logic [DW-1:0] bb,
                       input logic [3:0] c, input logic [4:0] s);
    req_valid[k] = v;
    a[k]   = aa;
    b[k]   = bb;
    ctl[k] = c;
    sh[k]  = s;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor: every completed response handshake pops one entry.
  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid_o && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_result_o), 32'hDEAD_BEEF);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        n_popped++;
        check("rsp_id",     32'(rsp_id_o),     32'(e.id));
        check("rsp_result", rsp_result_o,      e.res);
        check("rsp_zero",   32'(rsp_zero_o),   32'(e.zero));
      end
    end
  end

  // Requester rule: valid and operand A hold until accepted.
  logic [NR-1:0] vld_q = '0, rdy_q = '0;
  logic [DW-1:0] a_q [NR];
  always @(negedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < NR; k++) begin
        if (vld_q[k] && !rdy_q[k]) begin
          assert (req_valid[k] && a[k] == a_q[k])
            else $error("requester %0d dropped or changed an unaccepted request", k);
        end
      end
    end
    vld_q <= rst_i ? '0 : req_valid;
    rdy_q <= req_ready_o;
    for (int k = 0; k < NR; k++) a_q[k] <= a[k];
  end

  logic [DW-1:0] xa [3] = '{32'hF0F0_0000, 32'h0000_1234, 32'hA5A5_A5A5};
  logic [DW-1:0] xb [3] = '{32'h0F0F_0000, 32'h0000_1234, 32'hFFFF_FFFF};
  logic [DW-1:0] oa [3] = '{32'h0000_0001, 32'h0000_FF00, 32'h8000_0000};
  logic [DW-1:0] ob [3] = '{32'h0000_0002, 32'h0000_00FF, 32'h0000_0000};

  initial begin
    int n [NR];
    rst_i     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < NR; k++) begin
      drive(k, 1'b0, '0, '0, OP_ADD, '0);
      n[k] = 0;
    end
    tick();
    tick();
    @(negedge clk_i);
    check("reset_rsp_valid",  32'(rsp_valid_o),  32'd0);
    check("reset_rsp_id",     32'(rsp_id_o),     32'd0);
    check("reset_rsp_result", rsp_result_o,      32'd0);
    check("reset_rsp_zero",   32'(rsp_zero_o),   32'd0);
    check("reset_req_ready",  32'(req_ready_o),  32'd0);
    tick();
    rst_i = 1'b0;

    // Single ADD from requester 0.
    drive(0, 1'b1, 32'd5, 32'd7, OP_ADD, 5'd0);
    exp_q.push_back(mk(1'b0, 32'd12, 1'b0));
    @(negedge clk_i);
    check("t1_req_ready", 32'(req_ready_o), 32'b01);
    check("t1_pre_valid", 32'(rsp_valid_o), 32'd0);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk_i);
    check("t1_rsp_valid", 32'(rsp_valid_o), 32'd1);

    // Zero flag from requester 1.
    tick();
    drive(1, 1'b1, 32'd9, 32'd9, OP_SUB, 5'd0);
    exp_q.push_back(mk(1'b1, 32'd0, 1'b1));
    @(negedge clk_i);
    check("t2_req_ready", 32'(req_ready_o), 32'b10);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk_i);
    check("idle_alu_a",   alu_a_o,          32'd0);
    check("idle_alu_ctl", 32'(alu_ctl_o),   32'(OP_ADD));

    // Round-robin: XOR stream on 0, OR stream on 1, both continuously valid.
    tick();
    drive(0, 1'b1, xa[0], xb[0], OP_XOR, 5'd0);
    drive(1, 1'b1, oa[0], ob[0], OP_OR,  5'd0);
    exp_q.push_back(mk(1'b0, 32'hFFFF_0000, 1'b0));
    exp_q.push_back(mk(1'b1, 32'h0000_0003, 1'b0));
    exp_q.push_back(mk(1'b0, 32'h0000_0000, 1'b1));
    exp_q.push_back(mk(1'b1, 32'h0000_FFFF, 1'b0));
    exp_q.push_back(mk(1'b0, 32'h5A5A_5A5A, 1'b0));
    exp_q.push_back(mk(1'b1, 32'h8000_0000, 1'b0));
    for (int i = 0; i < 6; i++) begin
      int k;
      k = i % 2;
      @(negedge clk_i);
      check("rr_grant", 32'(req_ready_o), (k == 0) ? 32'b01 : 32'b10);
      tick();
      n[k]++;
      if (n[k] < 3) begin
        if (k == 0) drive(0, 1'b1, xa[n[0]], xb[n[0]], OP_XOR, 5'd0);
        else        drive(1, 1'b1, oa[n[1]], ob[n[1]], OP_OR,  5'd0);
      end else begin
        req_valid[k] = 1'b0;
      end
    end
    @(negedge clk_i);

    // Backpressure: three stalled cycles with both requesters waiting.
    tick();
    drive(0, 1'b1, 32'd1, 32'd1, OP_ADD, 5'd0);
    drive(1, 1'b1, 32'd2, 32'd2, OP_ADD, 5'd0);
    exp_q.push_back(mk(1'b0, 32'd2, 1'b0));
    @(negedge clk_i);
    check("bp_first_grant", 32'(req_ready_o), 32'b01);
    tick();
    rsp_ready = 1'b0;
    drive(0, 1'b1, 32'd3, 32'd3, OP_ADD, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("bp_stall_ready",  32'(req_ready_o),  32'b00);
      check("bp_stall_valid",  32'(rsp_valid_o),  32'd1);
      check("bp_stall_result", rsp_result_o,      32'd2);
      check("bp_stall_id",     32'(rsp_id_o),     32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk_i);
    check("bp_resume_grant", 32'(req_ready_o), 32'b10);
    exp_q.push_back(mk(1'b1, 32'd4, 1'b0));
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk_i);
    check("bp_next_grant", 32'(req_ready_o), 32'b01);
    exp_q.push_back(mk(1'b0, 32'd6, 1'b0));
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk_i);

    // Shift routing from requester 1.
    tick();
    drive(1, 1'b1, 32'h8000_0000, 32'd0, OP_SRA, 5'd4);
    exp_q.push_back(mk(1'b1, 32'hF800_0000, 1'b0));
    @(negedge clk_i);
    check("sra_alu_shamt", 32'(alu_shamt_o), 32'd4);
    check("sra_alu_ctl",   32'(alu_ctl_o),   32'(OP_SRA));
    check("sra_alu_a",     alu_a_o,          32'h8000_0000);
    check("sra_req_ready", 32'(req_ready_o), 32'b10);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk_i);

    // Reset while a response is stalled.
    tick();
    rsp_ready = 1'b0;
    drive(0, 1'b1, 32'd10, 32'd20, OP_ADD, 5'd0);
    exp_q.push_back(mk(1'b0, 32'd30, 1'b0));
    @(negedge clk_i);
    check("rst_pre_grant", 32'(req_ready_o), 32'b01);
    tick();
    rst_i = 1'b1;
    drive(0, 1'b1, 32'd5, 32'd5, OP_ADD, 5'd0);
    drive(1, 1'b1, 32'd4, 32'd4, OP_ADD, 5'd0);
    @(negedge clk_i);
    check("rst_held_valid", 32'(rsp_valid_o), 32'd1);
    check("rst_req_ready",  32'(req_ready_o), 32'b00);
    tick();
    rst_i     = 1'b0;
    rsp_ready = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    check("rst_dropped_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_first_grant",   32'(req_ready_o), 32'b01);
    exp_q.push_back(mk(1'b0, 32'd10, 1'b0));
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk_i);
    check("rst_second_grant", 32'(req_ready_o), 32'b10);
    exp_q.push_back(mk(1'b1, 32'd8, 1'b0));
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk_i);
    tick();
    @(negedge clk_i);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    check("responses_seen",   32'(n_popped),     32'd14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational alu instance between NUM_REQ requesters, e.g. the main execute path and a branch-compare/address-generation unit.
- Each cycle a round-robin arbiter picks one valid request and drives its operands and control onto the ALU.
- The result is captured into a single response register with valid/ready backpressure, tagged with the requester ID.
- Located in the execute stage, between the requesters and the alu instance.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the alu instance.
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ) (minimum 1), width of rsp_id_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a_i  in  NUM_REQ*DATA_WIDTH  operand A, requester k in slice [k*DATA_WIDTH +: DATA_WIDTH].
- req_b_i  in  NUM_REQ*DATA_WIDTH  operand B, same packing.
- req_ctl_i  in  NUM_REQ*4  ALU op per requester (alu_pkg encodings).
- req_shamt_i  in  NUM_REQ*5  shift amount per requester.
- alu_a_o  out  DATA_WIDTH  operand A to the alu.
- alu_b_o  out  DATA_WIDTH  operand B to the alu.
- alu_ctl_o  out  4  control to the alu.
- alu_shamt_o  out  5  shift amount to the alu.
- alu_result_i  in  DATA_WIDTH  combinational result from the alu.
- rsp_valid_o  out  1  response register holds a result.
- rsp_ready_i  in  1  consumer accepts the response.
- rsp_id_o  out  ID_W  index of the requester that owns the response.
- rsp_result_o  out  DATA_WIDTH  captured result.
- rsp_zero_o  out  1  captured (result == 0), computed locally.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, rsp_zero_o=0, ptr=NUM_REQ-1, so requester 0 has first priority.
- Advance condition: adv = !rsp_valid_o || rsp_ready_i, which allows a pipelined back-to-back handoff.
- Arbitration (combinational):
  - Search req_valid_i starting at ptr+1, modulo NUM_REQ; the first set bit is the grant g.
  - req_ready_o[g] = adv. All other ready bits are 0.
  - With no valid request or with adv=0, all ready bits are 0.
- ALU drive:
  - When a grant exists, alu_* carries requester g's slices, regardless of adv.
  - Otherwise alu_a_o, alu_b_o and alu_shamt_o are 0 and alu_ctl_o = ALU_ADD.
- Accept: fire = req_valid_i[g] && req_ready_o[g]. On the rising edge when fire is set:
  - rsp_result_o <= alu_result_i; rsp_zero_o <= (alu_result_i == 0); rsp_id_o <= g;
  - rsp_valid_o <= 1; ptr <= g.
- Latency: a response appears exactly 1 cycle after acceptance. Throughput is 1 op/cycle when rsp_ready_i is held high.
- Consume: if rsp_valid_o && rsp_ready_i && !fire, then rsp_valid_o <= 0. If both happen in the same cycle, the new result replaces the old one and rsp_valid_o stays 1.
- Stall: while rsp_valid_o && !rsp_ready_i, the response fields hold stable, no requester is accepted and ptr is unchanged.
- ptr changes only on fire. An idle cycle does not rotate priority.
- Fairness: with all requesters continuously valid and no stall, grants cycle 0,1,..,NUM_REQ-1,0,...
  - Starvation bound: no valid requester waits more than NUM_REQ-1 accepts by others.
- Requester rules (asserted in the bench, not checked in RTL):
  - valid must not depend combinationally on ready.
  - Once asserted, valid and payload must hold until accepted.
- Reset mid-operation: the in-flight response is dropped (rsp_valid_o -> 0) and ptr returns to NUM_REQ-1 on the reset edge. req_ready_o is 0 during reset.
- Width rules:
  - rsp_zero_o compares all DATA_WIDTH bits.
  - alu_shamt_o is passed through unmodified (5 bits, no masking).
  - Unused ctl codes are passed through; the alu defines their result.

Test Plan:
- Reset then single op:
  - Stimulus: req0 ADD A=5 B=7 with rsp_ready_i=1.
  - Required: req_ready_o=01 in cycle 0; cycle 1 has rsp_valid_o=1, rsp_id_o=0, rsp_result_o=12, rsp_zero_o=0.
- Zero flag:
  - Stimulus: req1 SUB A=9 B=9 alone.
  - Required: rsp_result_o=0, rsp_zero_o=1, rsp_id_o=1.
- Round-robin under contention:
  - Stimulus: both requesters continuously valid, with req0 XOR and req1 OR streams, rsp_ready_i=1.
  - Required: response IDs 0,1,0,1... on consecutive cycles with no bubbles.
- Backpressure:
  - Stimulus: rsp_ready_i=0 for 3 cycles while a response is pending and both requests are valid.
  - Required: req_ready_o=00 for those cycles and the response is unchanged; when rsp_ready_i rises, a new accept occurs in the same cycle and the next grant goes to the requester after the last one granted.
- Shift routing:
  - Stimulus: req1 SRA A=0x80000000 shamt=4 while req0 is idle.
  - Required: alu_shamt_o=4 and the registered result matches the alu output for requester 1.
- Reset mid-stall:
  - Stimulus: assert rst_i for 1 cycle with rsp_valid_o=1 and rsp_ready_i=0.
  - Required: rsp_valid_o=0 next cycle; the first post-reset contention grants requester 0.
